// File: rtl/apb_exe_ctrl_if.sv
// APB bus bundle between a bus master and the apb_exe_ctrl register block.
// Widths are fixed: 5-bit word address space, 32-bit data.
interface apb_exe_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_exe_ctrl.sv
// APB-controlled sequencer for a fixed-latency execution unit.
// Holds operands A/B and an opcode, launches an operation on a CTRL start
// write, captures result_in LAT cycles later and reports busy/done/err.
// A RESULT read issued while the operation runs is stalled until capture.
// Optional feature: define APB_EXE_CTRL_IRQ_EN to add the irq output and
// the CTRL[4] irq enable bit.
//
// state  | meaning
// S_IDLE | waiting for a start write
// S_EXEC | operation running, counting down LAT cycles
// S_DONE | result just captured, one cycle before returning to idle
module apb_exe_ctrl #(
  parameter int N   = 8,
  parameter int LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  apb_exe_ctrl_if.slave       apb,
  output logic signed [N-1:0] op_a,
  output logic signed [N-1:0] op_b,
  output logic [2:0]          opcode,
  input  logic signed [N-1:0] result_in
`ifdef APB_EXE_CTRL_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam logic [4:0] ADDR_A      = 5'h00;
  localparam logic [4:0] ADDR_B      = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic signed [N-1:0] a_q, b_q, result_q;
  logic [2:0]          opcode_q;
  logic                irq_en_q;
  logic                done_q, err_q;

  logic        access, stall, xfer, wr, rd, busy;
  logic        sel_a, sel_b, sel_ctrl, sel_stat, sel_res, mapped;
  logic        slverr, wr_ok, busy_rej, start;
  logic [31:0] rdata;

  // Address decode, wait-state and error qualification of the current access
  always_comb begin
    access   = apb.PSEL & apb.PENABLE;
    sel_a    = (apb.PADDR == ADDR_A);
    sel_b    = (apb.PADDR == ADDR_B);
    sel_ctrl = (apb.PADDR == ADDR_CTRL);
    sel_stat = (apb.PADDR == ADDR_STATUS);
    sel_res  = (apb.PADDR == ADDR_RESULT);
    mapped   = sel_a | sel_b | sel_ctrl | sel_stat | sel_res;
    busy     = (state_q != S_IDLE);
    // Only the capture cycle makes RESULT fresh; DONE already holds it.
    stall    = access & ~apb.PWRITE & sel_res & (state_q == S_EXEC);
    xfer     = access & ~stall;
    wr       = xfer & apb.PWRITE;
    rd       = xfer & ~apb.PWRITE;
    busy_rej = wr & busy & (sel_a | sel_b | sel_ctrl);
    slverr   = ~mapped | (apb.PWRITE & (sel_stat | sel_res)) | busy_rej;
    wr_ok    = wr & ~slverr;
    start    = wr_ok & sel_ctrl & apb.PWDATA[3];
    rdata    = 32'h0;
    if (sel_a)    rdata = 32'(a_q);
    if (sel_b)    rdata = 32'(b_q);
    if (sel_ctrl) rdata = {27'h0, irq_en_q, 1'b0, opcode_q};
    if (sel_stat) rdata = {29'h0, err_q, done_q, busy};
    if (sel_res)  rdata = 32'(result_q);
  end

  assign apb.PRDATA  = rd ? rdata : 32'h0;
  assign apb.PREADY  = ~stall;
  assign apb.PSLVERR = xfer & slverr;

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign opcode = opcode_q;

  // Upper write-data bits have no destination in narrower configurations
  logic unused_wdata;
  assign unused_wdata = &{1'b0, apb.PWDATA};

  // Register file: operand/control writes accepted only while idle, sticky err
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= 3'd0;
      irq_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr_ok & sel_a) a_q <= apb.PWDATA[N-1:0];
      if (wr_ok & sel_b) b_q <= apb.PWDATA[N-1:0];
      if (wr_ok & sel_ctrl) begin
        opcode_q <= apb.PWDATA[2:0];
`ifdef APB_EXE_CTRL_IRQ_EN
        irq_en_q <= apb.PWDATA[4];
`endif
      end
      if (busy_rej) err_q <= 1'b1;
      else if (rd & sel_stat) err_q <= 1'b0;
    end
  end

  // Operation sequencer: latency down-counter, result capture and done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      if (rd & sel_res) done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_EXEC;
            cnt_q   <= 4'(LAT - 1);
            done_q  <= 1'b0;
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            result_q <= result_in;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef APB_EXE_CTRL_IRQ_EN
  logic irq_q;

  // Interrupt is a registered copy of the enabled done flag
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= done_q & irq_en_q;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_apb_exe_ctrl.sv
// Directed bench for apb_exe_ctrl (N=8, LAT=3). The execution unit is modelled
// by the bench: either a small arithmetic model or a forced value, so that the
// capture instant can be pinned to exactly LAT cycles after the start write.
module tb_apb_exe_ctrl;
  localparam int N   = 8;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_exe_ctrl_if apb();
  logic signed [N-1:0] op_a, op_b, result_in;
  logic [2:0]          opcode;
`ifdef APB_EXE_CTRL_IRQ_EN
  logic irq;
`endif

  apb_exe_ctrl #(.N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .apb       (apb),
    .op_a      (op_a),
    .op_b      (op_b),
    .opcode    (opcode),
    .result_in (result_in)
`ifdef APB_EXE_CTRL_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic                model_en = 1'b0;
  logic signed [N-1:0] res_force = '0;

  // Execution-unit model: 0 add, 1 sub, others xor
  always_comb begin
    result_in = res_force;
    if (model_en) begin
      case (opcode)
        3'd0:    result_in = op_a + op_b;
        3'd1:    result_in = op_a - op_b;
        default: result_in = op_a ^ op_b;
      endcase
    end
  end

  // One APB transfer; entered and left just after a rising edge, so calls chain
  // back to back with no idle cycle in between.
  task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!apb.PREADY && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    checks++;
    if (!apb.PREADY) begin
      errors++;
      $display("FAIL pready_timeout addr=%h waits=%0d required ready within 50", addr, waits);
    end
    rdata = apb.PRDATA;
    err   = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e; int w;
    @(negedge clk);
    checks++; if (apb.PREADY !== 1'b1) begin errors++; $display("FAIL rst_pready got=%b exp=1", apb.PREADY); end
    checks++; if (apb.PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_pslverr got=%b exp=0", apb.PSLVERR); end
    checks++; if (apb.PRDATA !== 32'h0) begin errors++; $display("FAIL rst_prdata got=%h exp=0", apb.PRDATA); end
    checks++; if ({op_a, op_b, opcode} !== '0) begin errors++; $display("FAIL rst_ops got a=%h b=%h op=%h exp 0", op_a, op_b, opcode); end
    @(posedge clk); #1;
    rst = 1'b0;
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got=%h exp=0", d); end
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL rst_result got=%h err=%b exp=0 err=0", d, e); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic e; int w;
    model_en = 1'b0;
    apb_xfer(1'b1, 5'h00, 32'd6, d, e, w);
    apb_xfer(1'b1, 5'h04, 32'd8, d, e, w);
    res_force = 8'h55;
    apb_xfer(1'b1, 5'h08, 32'h0A, d, e, w);        // start, opcode 2
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_start_err got=%b exp=0", e); end
    // Value is only valid in the last EXEC cycle, so a wrong latency captures 0x55 or 0x33
    repeat (LAT - 1) @(posedge clk);
    #1 res_force = -8'sd1;
    @(posedge clk); #1;
    res_force = 8'h33;
    checks++; if (op_a !== 8'sd6 || op_b !== 8'sd8 || opcode !== 3'd2) begin
      errors++; $display("FAIL basic_ports got a=%h b=%h op=%h exp 06 08 2", op_a, op_b, opcode); end
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_status got=%h exp=2", d); end
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    checks++; if (d !== 32'hFFFF_FFFF || w != 0) begin errors++; $display("FAIL basic_result got=%h waits=%0d exp=ffffffff waits=0", d, w); end
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_done_clear got=%h exp=0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic e; int w;
    apb_xfer(1'b0, 5'h14, 32'h0, d, e, w);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h err=%b exp=0 err=1", d, e); end
    apb_xfer(1'b1, 5'h10, 32'h77, d, e, w);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_result_err got=%b exp=1", e); end
    apb_xfer(1'b1, 5'h0C, 32'h7, d, e, w);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_status_err got=%b exp=1", e); end
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    checks++; if (d !== 32'hFFFF_FFFF || e !== 1'b0) begin errors++; $display("FAIL unmapped_keep_result got=%h err=%b exp=ffffffff err=0", d, e); end
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_status got=%h exp=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic e; int w;
    apb_xfer(1'b1, 5'h00, 32'h1234_56FA, d, e, w);
    apb_xfer(1'b0, 5'h00, 32'h0, d, e, w);
    checks++; if (d !== 32'hFFFF_FFFA) begin errors++; $display("FAIL rd_a_sext got=%h exp=fffffffa", d); end
    apb_xfer(1'b1, 5'h04, 32'h0000_007F, d, e, w);
    apb_xfer(1'b0, 5'h04, 32'h0, d, e, w);
    checks++; if (d !== 32'h0000_007F) begin errors++; $display("FAIL rd_b got=%h exp=0000007f", d); end
    apb_xfer(1'b1, 5'h08, 32'h12, d, e, w);
    apb_xfer(1'b0, 5'h08, 32'h0, d, e, w);
`ifdef APB_EXE_CTRL_IRQ_EN
    checks++; if (d !== 32'h12) begin errors++; $display("FAIL rd_ctrl got=%h exp=12", d); end
`else
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL rd_ctrl got=%h exp=02", d); end
`endif
    checks++; if (opcode !== 3'd2) begin errors++; $display("FAIL opcode_port got=%h exp=2", opcode); end
    // Setup phase alone must not write anything
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 5'h00; apb.PWDATA = 32'h44;
    @(negedge clk);
    checks++; if (apb.PSLVERR !== 1'b0 || apb.PRDATA !== 32'h0) begin
      errors++; $display("FAIL setup_outputs got err=%b data=%h exp 0 0", apb.PSLVERR, apb.PRDATA); end
    @(posedge clk); @(posedge clk); #1;
    apb.PSEL = 1'b0;
    @(posedge clk); #1;
    checks++; if (op_a !== -8'sd6) begin errors++; $display("FAIL setup_no_write got=%h exp=fa", op_a); end
  endtask

  task automatic test_stall();
    logic [31:0] d; logic e; int w;
    model_en = 1'b1;
    apb_xfer(1'b1, 5'h00, 32'hFA, d, e, w);
    apb_xfer(1'b1, 5'h04, 32'hF8, d, e, w);
    apb_xfer(1'b1, 5'h08, 32'h08, d, e, w);         // start, add
    // Read SETUP lands in the first EXEC cycle, so ACCESS waits the remaining LAT-1
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    checks++; if (w != LAT - 1) begin errors++; $display("FAIL stall_waits got=%0d exp=%0d", w, LAT - 1); end
    checks++; if (d !== 32'hFFFF_FFF2 || e !== 1'b0) begin errors++; $display("FAIL stall_result got=%h err=%b exp=fffffff2 err=0", d, e); end
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stall_status got=%h exp=0", d); end
  endtask

  task automatic test_busy_reject();
    logic [31:0] d; logic e; int w;
    model_en = 1'b1;
    apb_xfer(1'b1, 5'h00, 32'd3, d, e, w);
    apb_xfer(1'b1, 5'h04, 32'd1, d, e, w);
    apb_xfer(1'b1, 5'h08, 32'h09, d, e, w);         // start, sub
    apb_xfer(1'b1, 5'h00, 32'd5, d, e, w);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL busy_wr_a_err got=%b exp=1", e); end
    checks++; if (op_a !== 8'sd3) begin errors++; $display("FAIL busy_a_kept got=%h exp=03", op_a); end
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);          // ACCESS in DONE
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL busy_status got=%h exp=7", d); end
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL err_cleared got=%h exp=2", d); end
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL sub_result got=%h exp=2", d); end
    apb_xfer(1'b1, 5'h08, 32'h08, d, e, w);         // start, add
    apb_xfer(1'b1, 5'h08, 32'h0A, d, e, w);         // rejected start
    checks++; if (e !== 1'b1 || opcode !== 3'd0) begin errors++; $display("FAIL busy_ctrl got err=%b op=%h exp err=1 op=0", e, opcode); end
    repeat (5) @(posedge clk);
    #1;
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL idle_err_status got=%h exp=6", d); end
    // New start clears a pending done
    apb_xfer(1'b1, 5'h08, 32'h08, d, e, w);
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL restart_status got=%h exp=1", d); end
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL add_result got=%h exp=4", d); end
    apb_xfer(1'b1, 5'h08, 32'h09, d, e, w);         // start right after the previous op
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL b2b_start_err got=%b exp=0", e); end
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL b2b_result got=%h exp=2", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int w;
    apb_xfer(1'b1, 5'h08, 32'h08, d, e, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (op_a !== '0 || opcode !== 3'd0) begin errors++; $display("FAIL midrst_ports got a=%h op=%h exp 0", op_a, opcode); end
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_status got=%h exp=0", d); end
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    checks++; if (d !== 32'h0 || w != 0) begin errors++; $display("FAIL midrst_result got=%h waits=%0d exp=0 waits=0", d, w); end
    repeat (LAT + 2) @(posedge clk);
    #1;
    apb_xfer(1'b0, 5'h0C, 32'h0, d, e, w);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_no_done got=%h exp=0", d); end
  endtask

`ifdef APB_EXE_CTRL_IRQ_EN
  task automatic test_irq();
    logic [31:0] d; logic e; int w; int n;
    apb_xfer(1'b1, 5'h08, 32'h18, d, e, w);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
    n = 0;
    while (irq !== 1'b1 && n < LAT + 3) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq); end
    apb_xfer(1'b0, 5'h10, 32'h0, d, e, w);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 5'h0; apb.PWDATA = 32'h0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_unmapped();
    test_regs();
    test_stall();
    test_busy_reject();
    test_reset_mid();
`ifdef APB_EXE_CTRL_IRQ_EN
    test_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
